tlb_op_seq: RTL and testbench
=============================

// Module: tlb_op_seq
// PURPOSE
//   Sequences CP0 TLB instructions (TLBP/TLBR/TLBWI/TLBWR) between the MEM stage and the TLB array.
//   Snapshots CP0 Index/Random/EntryHi/PageMask/EntryLo0/1, runs a req/ack transaction on the array,
//   returns results to CP0 as a one-cycle tlbcmd pulse plus data, and stalls the pipeline until done.
// PARAMETERS
//   TLB_LINE   16  number of TLB entries
//   TLB_WIDTH  4   index width, = clog2(TLB_LINE)
// PORTS
//   clk            in   1   clock, all state updates on posedge
//   rst            in   1   synchronous reset, active-low (rst==0 resets)
//   op_valid_i     in   1   MEM-stage TLB instruction present; held while stall_o
//   op_i           in   2   00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//   exc_flush_i    in   1   exception/flush this cycle; blocks acceptance
//   op_ready_o     out  1   sequencer idle (IDLE state)
//   stall_o        out  1   hold pipeline
//   done_o         out  1   one-cycle completion pulse
//   cp0_index_i    in   32  CP0 Index
//   cp0_random_i   in   32  CP0 Random
//   cp0_entryhi_i/cp0_pagemask_i/cp0_entrylo0_i/cp0_entrylo1_i  in 32 each  CP0 values
//   tlb_req_o      out  1   array request, held until tlb_ack_i
//   tlb_op_o       out  2   00 probe, 01 read, 10 write
//   tlb_addr_o     out  TLB_WIDTH  entry index for read/write
//   tlb_entryhi_o/tlb_pagemask_o/tlb_entrylo0_o/tlb_entrylo1_o  out 32 each  snapshot write/probe data
//   tlb_ack_i      in   1   array done; read/probe results valid this cycle
//   tlb_hit_i      in   1   probe hit
//   tlb_hit_idx_i  in   TLB_WIDTH  probe hit index
//   tlb_r*_i (entryhi, pagemask, entrylo0, entrylo1)  in 32 each  read data
//   tlbcmd_o       out  4   CP0 strobe: [3] TLBP result, [2] TLBR result, [1] TLBWI, [0] TLBWR
//   index_o, entryhi_o, pagemask_o, entrylo0_o, entrylo1_o  out 32 each  results for CP0
// BEHAVIOUR
//   Reset (rst==0): state=IDLE. All registered outputs are 0, including tlb_req_o, tlbcmd_o,
//     done_o, and all data outputs and snapshots. op_ready_o=1, stall_o=0.
//   FSM IDLE -> ISSUE -> WB -> IDLE.
//   IDLE
//     - op_ready_o=1; stall_o = op_valid_i & ~exc_flush_i (combinational).
//     - Accept when op_valid_i & ~exc_flush_i.
//     - On accept, register op and snapshot the four CP0 entry registers.
//     - addr = cp0_index_i[TLB_WIDTH-1:0] for TLBR/TLBWI; cp0_random_i[TLB_WIDTH-1:0] for TLBWR;
//       upper bits are ignored. Next state ISSUE.
//   ISSUE
//     - tlb_req_o=1 with stable tlb_op_o/addr/data; stall_o=1.
//     - On tlb_ack_i, latch results and go to WB. ack may arrive the first ISSUE cycle.
//     - Without ack, stay in ISSUE indefinitely.
//     - tlb_op_o = 10 for both TLBWI and TLBWR.
//   WB (one cycle)
//     - stall_o=0, done_o=1, tlbcmd_o one-hot per the op; op_ready_o=0, so the held op_valid_i
//       is not re-accepted. Next state IDLE.
//     - TLBP hit: index_o = {1'b0, 0.., tlb_hit_idx_i}.
//     - TLBP miss: index_o = 32'h8000_0000 (P bit).
//     - TLBR: entryhi_o/pagemask_o/entrylo0_o/entrylo1_o = latched tlb_r*_i.
//     - Outputs not updated by the op keep their previous values.
//   Latency: accept at T, req at T+1, ack at T+1 at the earliest, WB/done at T+2.
//     Minimum stall is 2 cycles (T, T+1).
//   exc_flush_i has an effect only in IDLE. Once accepted, the op is the oldest instruction and
//     always completes; a write commits at ack.
//   tlbcmd_o and done_o are 0 outside WB; tlb_req_o is 0 outside ISSUE.
//   Reset asserted mid-ISSUE: the request drops next cycle, no tlbcmd_o pulse, and the array
//     sees the request abandoned.
// TESTING
//   TLBWI, cp0_index_i=32'h0000_0013, ack after 3 cycles -> tlb_addr_o=4'h3 and tlb_op_o=10 held 3 cycles;
//     tlbcmd_o=4'b0010 for 1 cycle; stall_o high 4 cycles.
//   TLBP, tlb_hit_i=1, tlb_hit_idx_i=4'h5, same-cycle ack -> index_o=32'h0000_0005, tlbcmd_o=4'b1000;
//     miss case -> index_o=32'h8000_0000.
//   TLBR from addr 7, tlb_rentryhi_i=32'hABCD_E0FF -> entryhi_o=32'hABCD_E0FF in WB, tlbcmd_o=4'b0100.
//   TLBWR, cp0_random_i=9, then cp0_random_i changed during ISSUE -> tlb_addr_o stays 9 (snapshot).
//   op_valid_i & exc_flush_i in IDLE -> no accept, stall_o=0, tlb_req_o never rises;
//     op_valid_i held through WB -> exactly one done_o pulse.
//   rst=0 during ISSUE -> next cycle tlb_req_o=0, state IDLE, all outputs 0, no tlbcmd_o pulse.

Source files
------------

// File: rtl/tlb_op_seq_if.sv
// rtl/tlb_op_seq_if.sv - TLB array request/response bus between the sequencer and the array
interface tlb_op_seq_if #(
  parameter int TLB_WIDTH = 4
);
  logic                 tlb_req;
  logic [1:0]           tlb_op;
  logic [TLB_WIDTH-1:0] tlb_addr;
  logic [31:0]          tlb_entryhi;
  logic [31:0]          tlb_pagemask;
  logic [31:0]          tlb_entrylo0;
  logic [31:0]          tlb_entrylo1;
  logic                 tlb_ack;
  logic                 tlb_hit;
  logic [TLB_WIDTH-1:0] tlb_hit_idx;
  logic [31:0]          tlb_rentryhi;
  logic [31:0]          tlb_rpagemask;
  logic [31:0]          tlb_rentrylo0;
  logic [31:0]          tlb_rentrylo1;

  modport master (
    output tlb_req, tlb_op, tlb_addr, tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1,
    input  tlb_ack, tlb_hit, tlb_hit_idx, tlb_rentryhi, tlb_rpagemask, tlb_rentrylo0, tlb_rentrylo1
  );

  modport slave (
    input  tlb_req, tlb_op, tlb_addr, tlb_entryhi, tlb_pagemask, tlb_entrylo0, tlb_entrylo1,
    output tlb_ack, tlb_hit, tlb_hit_idx, tlb_rentryhi, tlb_rpagemask, tlb_rentrylo0, tlb_rentrylo1
  );
endinterface

// File: rtl/tlb_op_seq.sv
// rtl/tlb_op_seq.sv - CP0 TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) between MEM stage and TLB array
module tlb_op_seq #(
  parameter int TLB_LINE  = 16,
  parameter int TLB_WIDTH = $clog2(TLB_LINE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [1:0]  op_i,
  input  logic        exc_flush_i,
  output logic        op_ready_o,
  output logic        stall_o,
  output logic        done_o,
  input  logic [31:0] cp0_index_i,
  input  logic [31:0] cp0_random_i,
  input  logic [31:0] cp0_entryhi_i,
  input  logic [31:0] cp0_pagemask_i,
  input  logic [31:0] cp0_entrylo0_i,
  input  logic [31:0] cp0_entrylo1_i,
  tlb_op_seq_if.master tlb,
  output logic [3:0]  tlbcmd_o,
  output logic [31:0] index_o,
  output logic [31:0] entryhi_o,
  output logic [31:0] pagemask_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_e;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [TLB_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]          ehi_q, ehi_d, pm_q, pm_d, lo0_q, lo0_d, lo1_q, lo1_d;
  logic [31:0]          index_q, index_d, rehi_q, rehi_d, rpm_q, rpm_d;
  logic [31:0]          rlo0_q, rlo0_d, rlo1_q, rlo1_d;
  logic                 accept;

  // Only the low index bits select an entry; the rest of Index/Random is ignored.
  logic unused_upper;
  assign unused_upper = ^{cp0_index_i[31:TLB_WIDTH], cp0_random_i[31:TLB_WIDTH]};

  assign accept = op_valid_i & ~exc_flush_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      addr_q  <= '0;
      ehi_q   <= '0;
      pm_q    <= '0;
      lo0_q   <= '0;
      lo1_q   <= '0;
      index_q <= '0;
      rehi_q  <= '0;
      rpm_q   <= '0;
      rlo0_q  <= '0;
      rlo1_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      ehi_q   <= ehi_d;
      pm_q    <= pm_d;
      lo0_q   <= lo0_d;
      lo1_q   <= lo1_d;
      index_q <= index_d;
      rehi_q  <= rehi_d;
      rpm_q   <= rpm_d;
      rlo0_q  <= rlo0_d;
      rlo1_q  <= rlo1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    ehi_d      = ehi_q;
    pm_d       = pm_q;
    lo0_d      = lo0_q;
    lo1_d      = lo1_q;
    index_d    = index_q;
    rehi_d     = rehi_q;
    rpm_d      = rpm_q;
    rlo0_d     = rlo0_q;
    rlo1_d     = rlo1_q;
    op_ready_o = 1'b0;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    tlbcmd_o   = 4'b0000;
    tlb.tlb_req = 1'b0;

    case (state_q)
      IDLE: begin
        op_ready_o = 1'b1;
        stall_o    = accept;
        if (accept) begin
          op_d   = op_i;
          addr_d = (op_i == OP_TLBWR) ? cp0_random_i[TLB_WIDTH-1:0] : cp0_index_i[TLB_WIDTH-1:0];
          ehi_d  = cp0_entryhi_i;
          pm_d   = cp0_pagemask_i;
          lo0_d  = cp0_entrylo0_i;
          lo1_d  = cp0_entrylo1_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tlb.tlb_req = 1'b1;
        stall_o     = 1'b1;
        // Results land straight in the CP0-facing registers so they are visible in WB.
        if (tlb.tlb_ack) begin
          state_d = WB;
          if (op_q == OP_TLBP) begin
            index_d = tlb.tlb_hit ? {{(32-TLB_WIDTH){1'b0}}, tlb.tlb_hit_idx} : 32'h8000_0000;
          end else if (op_q == OP_TLBR) begin
            rehi_d = tlb.tlb_rentryhi;
            rpm_d  = tlb.tlb_rpagemask;
            rlo0_d = tlb.tlb_rentrylo0;
            rlo1_d = tlb.tlb_rentrylo1;
          end
        end
      end
      WB: begin
        done_o  = 1'b1;
        state_d = IDLE;
        case (op_q)
          OP_TLBP:  tlbcmd_o = 4'b1000;
          OP_TLBR:  tlbcmd_o = 4'b0100;
          OP_TLBWI: tlbcmd_o = 4'b0010;
          default:  tlbcmd_o = 4'b0001;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign tlb.tlb_op       = op_q[1] ? 2'b10 : op_q;
  assign tlb.tlb_addr     = addr_q;
  assign tlb.tlb_entryhi  = ehi_q;
  assign tlb.tlb_pagemask = pm_q;
  assign tlb.tlb_entrylo0 = lo0_q;
  assign tlb.tlb_entrylo1 = lo1_q;

  assign index_o    = index_q;
  assign entryhi_o  = rehi_q;
  assign pagemask_o = rpm_q;
  assign entrylo0_o = rlo0_q;
  assign entrylo1_o = rlo1_q;

endmodule

// File: tb/tb_tlb_op_seq.sv
// tb/tb_tlb_op_seq.sv - directed self-checking bench for tlb_op_seq
module tb_tlb_op_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic [1:0]  op_i;
  logic        exc_flush_i;
  logic        op_ready_o, stall_o, done_o;
  logic [31:0] cp0_index_i, cp0_random_i, cp0_entryhi_i, cp0_pagemask_i, cp0_entrylo0_i, cp0_entrylo1_i;
  logic [3:0]  tlbcmd_o;
  logic [31:0] index_o, entryhi_o, pagemask_o, entrylo0_o, entrylo1_o;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int done_cnt;

  tlb_op_seq_if #(.TLB_WIDTH(4)) tlb_bus ();

  tlb_op_seq #(.TLB_LINE(16), .TLB_WIDTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .op_valid_i     (op_valid_i),
    .op_i           (op_i),
    .exc_flush_i    (exc_flush_i),
    .op_ready_o     (op_ready_o),
    .stall_o        (stall_o),
    .done_o         (done_o),
    .cp0_index_i    (cp0_index_i),
    .cp0_random_i   (cp0_random_i),
    .cp0_entryhi_i  (cp0_entryhi_i),
    .cp0_pagemask_i (cp0_pagemask_i),
    .cp0_entrylo0_i (cp0_entrylo0_i),
    .cp0_entrylo1_i (cp0_entrylo1_i),
    .tlb            (tlb_bus.master),
    .tlbcmd_o       (tlbcmd_o),
    .index_o        (index_o),
    .entryhi_o      (entryhi_o),
    .pagemask_o     (pagemask_o),
    .entrylo0_o     (entrylo0_o),
    .entrylo1_o     (entrylo1_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks follow a further 1 unit of settling.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; op_valid_i = 1'b0; op_i = 2'b00; exc_flush_i = 1'b0;
    cp0_index_i = '0; cp0_random_i = '0; cp0_entryhi_i = '0; cp0_pagemask_i = '0;
    cp0_entrylo0_i = '0; cp0_entrylo1_i = '0;
    tlb_bus.tlb_ack = 1'b0; tlb_bus.tlb_hit = 1'b0; tlb_bus.tlb_hit_idx = '0;
    tlb_bus.tlb_rentryhi = '0; tlb_bus.tlb_rpagemask = '0;
    tlb_bus.tlb_rentrylo0 = '0; tlb_bus.tlb_rentrylo1 = '0;

    step(); step(); #1;
    chk("rst_ready", 32'(op_ready_o), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_tlbcmd", 32'(tlbcmd_o), 32'd0);
    chk("rst_req", 32'(tlb_bus.tlb_req), 32'd0);
    chk("rst_index", index_o, 32'd0);
    chk("rst_entryhi", entryhi_o, 32'd0);
    chk("rst_snap_ehi", tlb_bus.tlb_entryhi, 32'd0);

    // TLBWI, ack in the third ISSUE cycle
    step();
    rst = 1'b1; op_valid_i = 1'b1; op_i = 2'b10; cp0_index_i = 32'h0000_0013;
    cp0_entryhi_i = 32'hDEAD_0000; cp0_entrylo0_i = 32'h0000_1234;
    stall_cnt = 0;
    #1;
    chk("wi_idle_stall", 32'(stall_o), 32'd1);
    if (stall_o) stall_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) tlb_bus.tlb_ack = 1'b1;
      #1;
      chk("wi_req", 32'(tlb_bus.tlb_req), 32'd1);
      chk("wi_addr", 32'(tlb_bus.tlb_addr), 32'h3);
      chk("wi_op", 32'(tlb_bus.tlb_op), 32'h2);
      chk("wi_tlbcmd_issue", 32'(tlbcmd_o), 32'd0);
      if (stall_o) stall_cnt++;
    end
    chk("wi_snap_ehi", tlb_bus.tlb_entryhi, 32'hDEAD_0000);
    chk("wi_snap_lo0", tlb_bus.tlb_entrylo0, 32'h0000_1234);
    step();
    tlb_bus.tlb_ack = 1'b0; op_valid_i = 1'b0;
    #1;
    chk("wi_wb_tlbcmd", 32'(tlbcmd_o), 32'h2);
    chk("wi_wb_done", 32'(done_o), 32'd1);
    chk("wi_wb_ready", 32'(op_ready_o), 32'd0);
    chk("wi_wb_req", 32'(tlb_bus.tlb_req), 32'd0);
    if (stall_o) stall_cnt++;
    step(); #1;
    chk("wi_post_tlbcmd", 32'(tlbcmd_o), 32'd0);
    chk("wi_post_done", 32'(done_o), 32'd0);
    chk("wi_stall_cycles", 32'(stall_cnt), 32'd4);

    // TLBP hit, ack in the first ISSUE cycle
    op_valid_i = 1'b1; op_i = 2'b00;
    step();
    tlb_bus.tlb_ack = 1'b1; tlb_bus.tlb_hit = 1'b1; tlb_bus.tlb_hit_idx = 4'h5;
    #1;
    chk("p_req", 32'(tlb_bus.tlb_req), 32'd1);
    chk("p_op", 32'(tlb_bus.tlb_op), 32'h0);
    step();
    tlb_bus.tlb_ack = 1'b0; tlb_bus.tlb_hit = 1'b0; tlb_bus.tlb_hit_idx = 4'h0; op_valid_i = 1'b0;
    #1;
    chk("p_hit_index", index_o, 32'h0000_0005);
    chk("p_hit_tlbcmd", 32'(tlbcmd_o), 32'h8);
    chk("p_hit_stall", 32'(stall_o), 32'd0);

    // TLBP miss
    step();
    op_valid_i = 1'b1; op_i = 2'b00;
    step();
    tlb_bus.tlb_ack = 1'b1; tlb_bus.tlb_hit = 1'b0; tlb_bus.tlb_hit_idx = 4'hA;
    step();
    tlb_bus.tlb_ack = 1'b0; op_valid_i = 1'b0;
    #1;
    chk("p_miss_index", index_o, 32'h8000_0000);
    chk("p_miss_tlbcmd", 32'(tlbcmd_o), 32'h8);
    chk("p_miss_entryhi_kept", entryhi_o, 32'd0);

    // TLBR from entry 7
    step();
    op_valid_i = 1'b1; op_i = 2'b01; cp0_index_i = 32'hFFFF_FFF7;
    step();
    tlb_bus.tlb_ack = 1'b1; tlb_bus.tlb_rentryhi = 32'hABCD_E0FF;
    tlb_bus.tlb_rpagemask = 32'h0001_E000; tlb_bus.tlb_rentrylo0 = 32'h0000_0017;
    tlb_bus.tlb_rentrylo1 = 32'h0000_0057;
    #1;
    chk("r_addr", 32'(tlb_bus.tlb_addr), 32'h7);
    chk("r_op", 32'(tlb_bus.tlb_op), 32'h1);
    step();
    tlb_bus.tlb_ack = 1'b0; tlb_bus.tlb_rentryhi = '0; op_valid_i = 1'b0;
    #1;
    chk("r_entryhi", entryhi_o, 32'hABCD_E0FF);
    chk("r_pagemask", pagemask_o, 32'h0001_E000);
    chk("r_entrylo0", entrylo0_o, 32'h0000_0017);
    chk("r_entrylo1", entrylo1_o, 32'h0000_0057);
    chk("r_tlbcmd", 32'(tlbcmd_o), 32'h4);
    chk("r_index_kept", index_o, 32'h8000_0000);

    // TLBWR, Random changes while the request is outstanding
    step();
    op_valid_i = 1'b1; op_i = 2'b11; cp0_random_i = 32'd9; cp0_index_i = 32'd2;
    step();
    cp0_random_i = 32'd4;
    #1;
    chk("wr_addr0", 32'(tlb_bus.tlb_addr), 32'h9);
    chk("wr_op", 32'(tlb_bus.tlb_op), 32'h2);
    step();
    tlb_bus.tlb_ack = 1'b1;
    #1;
    chk("wr_addr1", 32'(tlb_bus.tlb_addr), 32'h9);
    step();
    tlb_bus.tlb_ack = 1'b0; op_valid_i = 1'b0;
    #1;
    chk("wr_tlbcmd", 32'(tlbcmd_o), 32'h1);
    chk("wr_entryhi_kept", entryhi_o, 32'hABCD_E0FF);

    // Flush in IDLE blocks acceptance
    step();
    op_valid_i = 1'b1; op_i = 2'b10; exc_flush_i = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("fl_req", 32'(tlb_bus.tlb_req), 32'd0);
      chk("fl_ready", 32'(op_ready_o), 32'd1);
    end

    // Held op_valid_i through WB completes exactly once
    exc_flush_i = 1'b0;
    done_cnt = 0;
    step();
    tlb_bus.tlb_ack = 1'b1;
    #1;
    if (done_o) done_cnt++;
    step();
    tlb_bus.tlb_ack = 1'b0;
    #1;
    chk("hold_wb_ready", 32'(op_ready_o), 32'd0);
    if (done_o) done_cnt++;
    step();
    op_valid_i = 1'b0;
    #1;
    if (done_o) done_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (done_o) done_cnt++;
    end
    chk("hold_done_once", 32'(done_cnt), 32'd1);

    // Reset while ISSUE is pending
    op_valid_i = 1'b1; op_i = 2'b10; cp0_index_i = 32'd6; cp0_entryhi_i = 32'h1111_2222;
    step();
    op_valid_i = 1'b0;
    #1;
    chk("rs_req_before", 32'(tlb_bus.tlb_req), 32'd1);
    rst = 1'b0;
    step(); #1;
    chk("rs_req", 32'(tlb_bus.tlb_req), 32'd0);
    chk("rs_ready", 32'(op_ready_o), 32'd1);
    chk("rs_tlbcmd", 32'(tlbcmd_o), 32'd0);
    chk("rs_done", 32'(done_o), 32'd0);
    chk("rs_index", index_o, 32'd0);
    chk("rs_entryhi", entryhi_o, 32'd0);
    chk("rs_snap_ehi", tlb_bus.tlb_entryhi, 32'd0);
    chk("rs_addr", 32'(tlb_bus.tlb_addr), 32'd0);
    rst = 1'b1;
    step(); #1;
    chk("rs_after_tlbcmd", 32'(tlbcmd_o), 32'd0);
    chk("rs_after_req", 32'(tlb_bus.tlb_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
